// File: rtl/aes_inv_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES InvMixColumns engine.
package aes_inv_pkg;

  localparam int unsigned STATE_W   = 128;
  localparam int unsigned COL_W     = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COL_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [BYTE_W-1:0] COEF_E = 8'h0e;
  localparam logic [BYTE_W-1:0] COEF_B = 8'h0b;
  localparam logic [BYTE_W-1:0] COEF_D = 8'h0d;
  localparam logic [BYTE_W-1:0] COEF_9 = 8'h09;

  // One column, byte a0/b0 in the most significant position.
  typedef struct packed {
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b2;
    logic [BYTE_W-1:0] b3;
  } col_t;

  // Multiply by x modulo 0x11B.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the four InvMixColumns coefficients via an xtime chain.
  function automatic logic [BYTE_W-1:0] gf_mul_inv(input logic [BYTE_W-1:0] a,
                                                   input logic [BYTE_W-1:0] coef);
    logic [BYTE_W-1:0] x2, x4, x8, res;
    x2  = xtime(a);
    x4  = xtime(x2);
    x8  = xtime(x4);
    res = '0;
    case (coef)
      COEF_E:  res = x8 ^ x4 ^ x2;
      COEF_B:  res = x8 ^ x2 ^ a;
      COEF_D:  res = x8 ^ x4 ^ a;
      COEF_9:  res = x8 ^ a;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inv_mix_col_32bit.sv
// Combinational InvMixColumns transform of a single 32-bit column.
module inv_mix_col_32bit
  import aes_inv_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_c_o
);

  col_t a;
  col_t b;

  assign a = col_t'(col_i);

  always_comb begin
    b.b0 = gf_mul_inv(a.b0, COEF_E) ^ gf_mul_inv(a.b1, COEF_B) ^
           gf_mul_inv(a.b2, COEF_D) ^ gf_mul_inv(a.b3, COEF_9);
    b.b1 = gf_mul_inv(a.b0, COEF_9) ^ gf_mul_inv(a.b1, COEF_E) ^
           gf_mul_inv(a.b2, COEF_B) ^ gf_mul_inv(a.b3, COEF_D);
    b.b2 = gf_mul_inv(a.b0, COEF_D) ^ gf_mul_inv(a.b1, COEF_9) ^
           gf_mul_inv(a.b2, COEF_E) ^ gf_mul_inv(a.b3, COEF_B);
    b.b3 = gf_mul_inv(a.b0, COEF_B) ^ gf_mul_inv(a.b1, COEF_D) ^
           gf_mul_inv(a.b2, COEF_9) ^ gf_mul_inv(a.b3, COEF_E);
  end

  assign col_c_o = COL_W'(b);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock, 128-bit valid/ready in and out.
module inv_mix_columns_iter
  import aes_inv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out
);

  state_e               state_q, state_d;
  logic [COL_IDX_W-1:0] col_q, col_d;
  logic [STATE_W-1:0]   work_q, work_d;
  logic                 in_ready_q, out_valid_q;
  logic [COL_W-1:0]     col_sel;
  logic [COL_W-1:0]     col_mix;

  // Column currently addressed by the counter; column 0 is the top word.
  always_comb begin
    col_sel = work_q[127:96];
    case (col_q)
      2'd0: col_sel = work_q[127:96];
      2'd1: col_sel = work_q[95:64];
      2'd2: col_sel = work_q[63:32];
      2'd3: col_sel = work_q[31:0];
      default: col_sel = work_q[127:96];
    endcase
  end

  inv_mix_col_32bit u_col (
    .col_i   (col_sel),
    .col_c_o (col_mix)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (col_q)
          2'd0: work_d[127:96] = col_mix;
          2'd1: work_d[95:64]  = col_mix;
          2'd2: work_d[63:32]  = col_mix;
          2'd3: work_d[31:0]   = col_mix;
          default: work_d = work_q;
        endcase
        col_d = col_q + COL_IDX_W'(1);
        if (col_q == COL_IDX_W'(3)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = work_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter with a software GF(2^8) reference model.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int n_vec;
  int n_miss;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Apply a circulant column matrix whose first row is (m0 m1 m2 m3).
  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic [31:0] row);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [31:0]  col;
    r = '0;
    for (int k = 0; k < 4; k++) m[k] = row[31-8*k -: 8];
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[(j - i + 4) % 4], a[j]);
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic accept_and_run(input logic [127:0] d, input logic [127:0] exp, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, 128'(in_ready), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_out_valid_e%0d", tag, k), 128'(out_valid), 128'(k == 4));
    end
    check({tag, "_data"}, data_out, exp);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_hs_out_valid"}, 128'(out_valid), 128'(0));
  endtask

  logic [127:0] st [3];
  int idx_in, idx_out, last;
  bit pend;

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out", data_out, 128'(0));
    rst = 1'b0;

    accept_and_run(V1, E1, "v1");
    handshake("v1");
    accept_and_run(V2, E2, "v2");
    handshake("v2");

    // Stall in DONE while other data is offered.
    accept_and_run(V1, E1, "stall");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 1);
      data_in  = V2 ^ 128'(i);
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", 128'(out_valid), 128'(1));
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_data", data_out, E1);
    end
    in_valid = 1'b0;
    handshake("stall");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_no_capture_valid", 128'(out_valid), 128'(0));
    check("stall_no_capture_ready", 128'(in_ready), 128'(1));

    // Abort with reset at E2.
    in_valid = 1'b1;
    data_in  = V2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_data_out", data_out, 128'(0));
    accept_and_run(V2, E2, "fresh");
    handshake("fresh");

    // Back-to-back with both handshakes held high.
    for (int i = 0; i < 3; i++) st[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    idx_in = 0;
    idx_out = 0;
    last = -1;
    data_in = st[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    pend = in_ready;
    for (int cyc = 0; cyc < 80 && idx_out < 3; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (pend) begin
        idx_in++;
        pend = 1'b0;
        if (idx_in < 3) data_in = st[idx_in];
        else in_valid = 1'b0;
      end
      if (in_valid && in_ready) pend = 1'b1;
      if (out_valid) begin
        check($sformatf("b2b_ref_%0d", idx_out), data_out, mix_state(st[idx_out], 32'h0e0b0d09));
        check($sformatf("b2b_fwd_%0d", idx_out), mix_state(data_out, 32'h02030101), st[idx_out]);
        if (last >= 0) check("b2b_period", 128'(cyc - last), 128'(6));
        last = cyc;
        idx_out++;
      end
    end
    check("b2b_results", 128'(idx_out), 128'(3));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_end_in_ready", 128'(in_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
# inv_mix_columns_iter

Iterative AES InvMixColumns engine for the decryption datapath: accepts a 128-bit state, applies the inverse column mixing one 32-bit column per clock, and presents the 128-bit result under a valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in each decryption round. It is the decryption-side counterpart of the encryption MixColumns column multiplier.

## Interface
Parameters: none. The block is fixed to AES with a 128-bit state and 32-bit columns.

Ports:
- clk  in  1  — single clock; all state changes on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — data_in is valid.
- in_ready  out  1  — block can accept a state.
- data_in  in  128  — input state. Column c occupies bits [127-32c : 96-32c]; byte a0 is the MSB of each column.
- out_valid  out  1  — data_out holds a finished result.
- out_ready  in  1  — consumer accepts data_out.
- data_out  out  128  — transformed state, in the same column and byte layout as data_in.

## Operation
- Per-column transform over GF(2^8), reduction polynomial 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from xtime chains: 09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2.
- State machine, 2-bit column counter col:
  - IDLE → RUN on in_valid & in_ready. The edge latches data_in into the working register and sets col = 0.
  - RUN: each edge replaces column col of the working register with its transform and increments col. The edge that processes col = 3 moves to DONE.
  - DONE → IDLE on out_ready. Otherwise hold: data_out and out_valid stay stable.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- data_out is driven from the working register. Its value is defined only while out_valid = 1.
- in_valid in RUN or DONE is ignored; no input is captured.
- out_ready outside DONE is ignored.

## Timing
- Reset values: state IDLE, col 0, working register 0. Consequently in_ready = 1, out_valid = 0, data_out = 0.
- Reset asserted in RUN or DONE aborts the operation. Outputs take their reset values after that edge, and no partial result is ever flagged valid.
- Latency: out_valid rises 4 cycles after the accepting edge. Accept at edge E0; columns 0–3 are processed at edges E1–E4; out_valid is high after E4.
- Output handshake at edge E5 with out_ready = 1 returns to IDLE, so in_ready is high after E5.
- Maximum throughput is one state per 6 cycles.
- out_ready held low in DONE: hold indefinitely, with no change to data_out.
- in_valid and out_ready are never required to be low. A continuously asserted in_valid starts a new operation on the first edge in IDLE.

## Structure
- Shared package aes_inv_pkg holds:
  - state encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - coefficient constants 8'h0e, 8'h0b, 8'h0d, 8'h09;
  - an xtime function.
- Sub-module inv_mix_col_32bit is the combinational 32-bit column transform. The block instantiates it once and muxes the column selected by col into it.
- All sequential logic lives in the top block.

## Test plan
- Reset, then apply data_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → after 4 cycles out_valid = 1 with data_out = db135345_f20a225c_01010101_c6c6c6c6.
- Apply data_in = d5d5d7d6_4d7ebdf8_c6c6c6c6_01010101 → data_out = d4d4d4d5_2d26314c_c6c6c6c6_01010101.
- Hold out_ready = 0 for 10 cycles in DONE, pulse in_valid with other data → out_valid and data_out stay stable, in_ready stays 0, and the new data is not captured.
- Assert rst at E2 of an operation → next cycle shows in_ready = 1, out_valid = 0, data_out = 0. A fresh operation afterwards yields the correct result.
- Back-to-back: keep in_valid = 1 and out_ready = 1 over three random states → each result matches a software InvMixColumns reference model, out_valid pulses every 6 cycles, and forward MixColumns of each output equals the corresponding input.
